// File: rtl/seg_display_scheduler.sv
// Seven-segment display scheduler: queues display words and shows each
// one for a fixed dwell time, back-to-back, with flush/hold/overflow.
module seg_display_scheduler #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32,
  parameter int DWELL  = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              hold,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] seg_out,
  output logic              showing,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;
  logic              ovf_set;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign showing = (state == SHOW);
  assign push    = wr_en && !full && !flush;
  assign ovf_set = wr_en && full && !flush;

  // Head pop: always in LOAD, and at dwell expiry in SHOW when more is queued.
  always_comb begin
    pop = 1'b0;
    if (!flush) begin
      unique case (state)
        LOAD:    pop = 1'b1;
        SHOW:    pop = !hold && (cnt == '0) && !empty;
        default: pop = 1'b0;
      endcase
    end
  end

  // Queue storage; stale entries are harmless since pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Pointers, level and the display FSM.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      seg_out <= '0;
      cnt     <= '0;
      state   <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (pop) begin
        seg_out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        cnt     <= CNT_LOAD;
      end

      unique case (state)
        IDLE: begin
          seg_out <= '0;
          if (!empty && !hold) state <= LOAD;
        end
        LOAD: state <= SHOW;
        SHOW: begin
          if (!hold) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (empty) begin
              seg_out <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with DWELL=4, DEPTH=4.
// Expected values are worked out by hand from the cycle timeline.
module tb_seg_display_scheduler;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              hold;
  logic              ovf_clr;
  logic [DATA_W-1:0] seg_out;
  logic              showing;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  seg_display_scheduler #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (8),
    .DWELL (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .flush   (flush),
    .hold    (hold),
    .ovf_clr (ovf_clr),
    .seg_out (seg_out),
    .showing (showing),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag,
                             input logic [31:0] w,
                             input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 32'(seg_out), w);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_seg"}, 32'(seg_out), 0);
    chk({tag, "_showing"}, 32'(showing), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    flush   = 1'b0;
    hold    = 1'b0;
    ovf_clr = 1'b0;

    // 1: reset
    step();
    step();
    chk_reset_state("rst");

    // 2: two words, latency and dwell
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 24'hA1;
    step();
    wr_data = 24'hB2;
    step();
    wr_en = 1'b0;
    chk("t2_load_seg", 32'(seg_out), 0);
    chk("t2_load_level", 32'(level), 2);
    chk("t2_load_showing", 32'(showing), 0);
    step();
    chk("t2_a1_first", 32'(seg_out), 32'hA1);
    chk("t2_showing", 32'(showing), 1);
    chk("t2_level1", 32'(level), 1);
    expect_word("t2_a1", 32'hA1, 3);
    expect_word("t2_b2", 32'hB2, 4);
    step();
    chk("t2_end_seg", 32'(seg_out), 0);
    chk("t2_end_showing", 32'(showing), 0);
    chk("t2_end_empty", 32'(empty), 1);

    // 3: fill under hold, overflow, ordered drain
    hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_en   = 1'b1;
      wr_data = DATA_W'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t3_full", 32'(full), 1);
    chk("t3_level", 32'(level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_hold_seg", 32'(seg_out), 0);
    chk("t3_hold_showing", 32'(showing), 0);
    hold = 1'b0;
    step();
    chk("t3_load_seg", 32'(seg_out), 0);
    expect_word("t3_w1", 1, 4);
    expect_word("t3_w2", 2, 4);
    expect_word("t3_w3", 3, 4);
    expect_word("t3_w4", 4, 4);
    step();
    chk("t3_no_w5", 32'(seg_out), 0);
    chk("t3_idle", 32'(showing), 0);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 0);

    // 4: six words spaced 4 cycles, pointers wrap
    for (int c = 0; c < 28; c++) begin
      wr_en   = (c % 4 == 0) && (c < 24);
      wr_data = DATA_W'(24'h10 + c / 4);
      step();
      if (c >= 2 && c < 26)
        chk("t4_seq", 32'(seg_out), 32'(24'h10 + (c - 2) / 4));
      else
        chk("t4_idle", 32'(seg_out), 0);
    end
    wr_en = 1'b0;
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_empty", 32'(empty), 1);

    // 5: hold for 3 cycles mid-show
    wr_en   = 1'b1;
    wr_data = 24'h51;
    step();
    wr_data = 24'h52;
    step();
    wr_en = 1'b0;
    expect_word("t5_x_pre", 32'h51, 2);
    hold = 1'b1;
    expect_word("t5_x_hold", 32'h51, 3);
    hold = 1'b0;
    expect_word("t5_x_post", 32'h51, 2);
    expect_word("t5_y", 32'h52, 4);
    step();
    chk("t5_end", 32'(seg_out), 0);

    // 6: flush with concurrent push while showing
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = DATA_W'(24'h60 + i);
      step();
    end
    chk("t6_pre_seg", 32'(seg_out), 32'h61);
    chk("t6_pre_level", 32'(level), 2);
    flush   = 1'b1;
    wr_data = 24'hCC;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("t6_seg", 32'(seg_out), 0);
    chk("t6_level", 32'(level), 0);
    chk("t6_showing", 32'(showing), 0);
    chk("t6_ovf", 32'(overflow), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t6_no_cc", 32'(seg_out), 0);
    end

    // 7: reset mid-show
    wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wr_data = DATA_W'(24'h70 + i);
      step();
    end
    wr_en = 1'b0;
    chk("t7_pre_level", 32'(level), 3);
    chk("t7_pre_seg", 32'(seg_out), 32'h71);
    rst_n = 1'b0;
    step();
    chk_reset_state("t7_rst");
    rst_n = 1'b1;
    step();
    chk("t7_after_seg", 32'(seg_out), 0);
    chk("t7_after_showing", 32'(showing), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
